dm_bus_bridge: RTL and testbench

DM_BUS_BRIDGE -- requirements
Module: dm_bus_bridge

---
 rtl/dm_bus_bridge_pkg.sv | 22 ++
 rtl/dm_bus_timer.sv | 42 ++++
 rtl/dm_bus_bridge.sv | 159 +++++++++++++++
 tb/tb_dm_bus_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dm_bus_bridge_pkg
// Shared core package: address/data types used by the core data path plus the
// bus-bridge FSM state encoding.
// -----------------------------------------------------------------------------
package dm_bus_bridge_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DONE = 2'd3
   } bridge_state_e;

endpackage

// File: rtl/dm_bus_timer.sv
// -----------------------------------------------------------------------------
// dm_bus_timer
// Per-phase wait counter for the bus bridge. Counts cycles while i_en is high,
// restarts from zero whenever i_clr is high, and flags o_expired during the
// LIMIT-th enabled cycle since the last clear.
//
// Ports:
//   i_clk      clock
//   i_rstn     synchronous active-low reset
//   i_clr      restart the count (phase entry / phase exit)
//   i_en       count this cycle (bridge waiting in REQ or RESP)
//   o_expired  current cycle is the LIMIT-th wait cycle of the phase
// -----------------------------------------------------------------------------
module dm_bus_timer
   import dm_bus_bridge_pkg::*;
#(
   parameter int unsigned LIMIT = 255
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn || i_clr) begin
         cnt_q <= '0;
      end else if (i_en && !o_expired) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // The count is zero in the first cycle of a phase, so LIMIT-1 marks the
   // LIMIT-th cycle spent in it.
   assign o_expired = i_en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dm_bus_bridge.sv
// -----------------------------------------------------------------------------
// dm_bus_bridge
// Bridges the core load/store port onto a valid/ready request bus with a
// separate rvalid read response. One transaction at a time; the core is
// stalled while a transaction is outstanding.
//
// Build option: DM_BUS_BRIDGE_TIMEOUT_EN -- when defined, each REQ/RESP wait
// is bounded by TIMEOUT_CYCLES and an expiry is reported on o_err.
//
// Ports:
//   i_clk, i_rstn                 clock, synchronous active-low reset
//   i_addr, i_wd, i_be            core address, store data, byte enables
//   i_wen, i_ren                  core store / load request
//   o_rd                          registered load data
//   o_stall                       core freeze while a transaction is pending
//   o_bus_valid/we/addr/wdata/be  bus request
//   i_bus_ready                   bus accepts the request
//   i_bus_rvalid, i_bus_rdata     read response
//   o_err                         one-cycle timeout pulse
// -----------------------------------------------------------------------------
module dm_bus_bridge
   import dm_bus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  addr_t           i_addr,
   input  data_t           i_wd,
   input  logic [BE_W-1:0] i_be,
   input  logic            i_wen,
   input  logic            i_ren,
   output data_t           o_rd,
   output logic            o_stall,
   output logic            o_bus_valid,
   output logic            o_bus_we,
   output addr_t           o_bus_addr,
   output data_t           o_bus_wdata,
   output logic [BE_W-1:0] o_bus_be,
   input  logic            i_bus_ready,
   input  logic            i_bus_rvalid,
   input  data_t           i_bus_rdata,
   output logic            o_err
);

   bridge_state_e   state_q;
   logic            valid_q;
   logic            we_q;
   addr_t           addr_q;
   data_t           wdata_q;
   logic [BE_W-1:0] be_q;
   data_t           rd_q;

   logic req_in;
   assign req_in = i_wen || i_ren;

`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
   logic err_q;
   logic tmr_en;
   logic tmr_clr;
   logic timeout_hit;

   // Restart the count on every phase change so REQ and RESP are each
   // bounded separately.
   assign tmr_en  = (state_q == REQ) || (state_q == RESP);
   assign tmr_clr = !tmr_en
                 || ((state_q == REQ)  && i_bus_ready)
                 || ((state_q == RESP) && i_bus_rvalid);

   dm_bus_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clr     (tmr_clr),
      .i_en      (tmr_en),
      .o_expired (timeout_hit)
   );

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= '0;
`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (req_in) begin
                  addr_q  <= i_addr;
                  wdata_q <= i_wd;
                  be_q    <= i_be;
                  we_q    <= i_wen;   // store wins when both are requested
                  valid_q <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (i_bus_ready) begin
                  valid_q <= 1'b0;
                  state_q <= we_q ? DONE : RESP;
`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
               end else if (timeout_hit) begin
                  valid_q <= 1'b0;
                  rd_q    <= '0;
                  err_q   <= 1'b1;
                  state_q <= DONE;
`endif
               end
            end
            // RESP is entered on the edge after the handshake, so a response
            // coinciding with the handshake cycle is never sampled here.
            RESP: begin
               if (i_bus_rvalid) begin
                  rd_q    <= i_bus_rdata;
                  state_q <= DONE;
`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
               end else if (timeout_hit) begin
                  rd_q    <= '0;
                  err_q   <= 1'b1;
                  state_q <= DONE;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_stall = (state_q == REQ) || (state_q == RESP)
                 || ((state_q == IDLE) && req_in);

   assign o_rd        = rd_q;
   assign o_bus_valid = valid_q;
   assign o_bus_we    = we_q;
   assign o_bus_addr  = addr_q;
   assign o_bus_wdata = wdata_q;
   assign o_bus_be    = be_q;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dm_bus_bridge
// Directed, table-driven bench for dm_bus_bridge. Works with or without
// DM_BUS_BRIDGE_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_dm_bus_bridge;
   import dm_bus_bridge_pkg::*;

   logic            i_clk = 1'b0;
   logic            i_rstn = 1'b0;
   addr_t           i_addr = '0;
   data_t           i_wd = '0;
   logic [3:0]      i_be = '0;
   logic            i_wen = 1'b0;
   logic            i_ren = 1'b0;
   data_t           o_rd;
   logic            o_stall;
   logic            o_bus_valid;
   logic            o_bus_we;
   addr_t           o_bus_addr;
   data_t           o_bus_wdata;
   logic [3:0]      o_bus_be;
   logic            i_bus_ready = 1'b0;
   logic            i_bus_rvalid = 1'b0;
   data_t           i_bus_rdata = '0;
   logic            o_err;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   always #5 i_clk = ~i_clk;

`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
   localparam int unsigned TMO = 4;
`else
   localparam int unsigned TMO = 255;
`endif

   dm_bus_bridge #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (i_clk),
      .i_rstn       (i_rstn),
      .i_addr       (i_addr),
      .i_wd         (i_wd),
      .i_be         (i_be),
      .i_wen        (i_wen),
      .i_ren        (i_ren),
      .o_rd         (o_rd),
      .o_stall      (o_stall),
      .o_bus_valid  (o_bus_valid),
      .o_bus_we     (o_bus_we),
      .o_bus_addr   (o_bus_addr),
      .o_bus_wdata  (o_bus_wdata),
      .o_bus_be     (o_bus_be),
      .i_bus_ready  (i_bus_ready),
      .i_bus_rvalid (i_bus_rvalid),
      .i_bus_rdata  (i_bus_rdata),
      .o_err        (o_err)
   );

   typedef struct {
      logic        wen;
      logic        ren;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      int unsigned rdly;       // ready-low cycles in REQ before the handshake
      int unsigned vdly;       // cycles from handshake to rvalid (loads)
      logic        rv_hs;      // also pulse rvalid (bogus data) in handshake cycle
      logic [31:0] rdata;
      int unsigned exp_stall;  // stall-high cycles
      logic        exp_we;
      logic [31:0] exp_rd;     // o_rd in the DONE cycle
   } vec_t;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle_inputs();
      i_wen = 1'b0; i_ren = 1'b0; i_addr = '0; i_wd = '0; i_be = '0;
      i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
   endtask

   // Starts at posedge+1 with the bridge in IDLE; returns at posedge+1 in IDLE.
   task automatic run_vec(input vec_t v, input int idx);
      int unsigned stall_n = 0;
      int unsigned valid_n = 0;
      bit done = 1'b0;
      i_wen = v.wen; i_ren = v.ren; i_addr = v.addr; i_wd = v.wd; i_be = v.be;
      for (int unsigned cyc = 0; cyc < 40 && !done; cyc++) begin
         if (cyc == 1) begin
            // scramble core inputs so the bus must show registered copies
            i_wen = 1'b0; i_ren = 1'b0;
            i_addr = ~v.addr; i_wd = ~v.wd; i_be = ~v.be;
         end
         i_bus_ready  = (cyc == 1 + v.rdly);
         i_bus_rvalid = !v.exp_we && ((cyc == 1 + v.rdly + v.vdly) ||
                                      (v.rv_hs && cyc == 1 + v.rdly));
         i_bus_rdata  = (cyc == 1 + v.rdly + v.vdly) ? v.rdata : 32'hBAD0BAD0;
         #4;
         if (o_bus_valid) begin
            valid_n++;
            chk($sformatf("v%0d bus_fields c%0d", idx, cyc),
                {47'd0, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be},
                {47'd0, v.exp_we, v.addr, v.wd, v.be});
         end
         if (o_stall) stall_n++;
         else if (cyc > 0) begin
            done = 1'b1;
            chk($sformatf("v%0d rd", idx), 80'(o_rd), 80'(v.exp_rd));
            chk($sformatf("v%0d err", idx), 80'(o_err), 80'(0));
            chk($sformatf("v%0d stall_cycles", idx), 80'(stall_n), 80'(v.exp_stall));
            chk($sformatf("v%0d valid_cycles", idx), 80'(valid_n), 80'(v.rdly + 1));
         end
         if (!done) begin @(posedge i_clk); #1; end
      end
      if (!done) chk($sformatf("v%0d completes", idx), 80'(0), 80'(1));
      idle_inputs();
      @(posedge i_clk); #1;
   endtask

   initial begin
      vec_t vecs[5];
      bit ok;
      int unsigned stall_n;
      int unsigned valid_n;
      bit done;

      vecs[0] = '{1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b0, 32'h0,
                  2, 1'b1, 32'h0};
      vecs[1] = '{1'b0, 1'b1, 32'h104, 32'h11111111, 4'hF, 3, 2, 1'b0, 32'h12345678,
                  7, 1'b0, 32'h12345678};
      vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'h3, 1, 1, 1'b0, 32'h0,
                  3, 1'b1, 32'h12345678};
      vecs[3] = '{1'b0, 1'b1, 32'h108, 32'h0, 4'hC, 0, 1, 1'b1, 32'hCAFEF00D,
                  3, 1'b0, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 1'b0, 32'h10C, 32'h0, 4'h1, 0, 0, 1'b0, 32'h0,
                  2, 1'b1, 32'hCAFEF00D};

      // reset state
      idle_inputs();
      i_rstn = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rstn = 1'b1;
      #4;
      chk("rst valid", 80'(o_bus_valid), 80'(0));
      chk("rst stall", 80'(o_stall), 80'(0));
      chk("rst rd", 80'(o_rd), 80'(0));
      chk("rst err", 80'(o_err), 80'(0));
      chk("rst bus_fields", {47'd0, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be}, 80'(0));
      @(posedge i_clk); #1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

      // reset while waiting in RESP
      i_ren = 1'b1; i_addr = 32'h300;
      @(posedge i_clk); #1;
      idle_inputs();
      i_bus_ready = 1'b1;
      @(posedge i_clk); #1;
      i_bus_ready = 1'b0;
      #4;
      chk("resp stall", 80'(o_stall), 80'(1));
      chk("resp valid", 80'(o_bus_valid), 80'(0));
      i_rstn = 1'b0;
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      #4;
      chk("midrst valid", 80'(o_bus_valid), 80'(0));
      chk("midrst rd", 80'(o_rd), 80'(0));
      chk("midrst stall", 80'(o_stall), 80'(0));
      @(posedge i_clk); #1;

      // load something so a timeout clearing o_rd is observable
      run_vec('{1'b0, 1'b1, 32'h110, 32'h0, 4'hF, 0, 1, 1'b0, 32'h5555AAAA,
                3, 1'b0, 32'h5555AAAA}, 5);

      // bus never accepts
      i_wen = 1'b1; i_addr = 32'h400; i_wd = 32'h0F0F0F0F; i_be = 4'hF;
`ifdef DM_BUS_BRIDGE_TIMEOUT_EN
      stall_n = 0; valid_n = 0; done = 1'b0;
      for (int unsigned cyc = 0; cyc < 50 && !done; cyc++) begin
         if (cyc == 1) i_wen = 1'b0;
         #4;
         if (o_bus_valid) valid_n++;
         if (o_stall) stall_n++;
         else if (cyc > 0) begin
            done = 1'b1;
            chk("tmo err", 80'(o_err), 80'(1));
            chk("tmo rd", 80'(o_rd), 80'(0));
            chk("tmo stall_cycles", 80'(stall_n), 80'(1 + TMO));
            chk("tmo valid_cycles", 80'(valid_n), 80'(TMO));
         end
         if (!done) begin @(posedge i_clk); #1; end
      end
      if (!done) chk("tmo completes", 80'(0), 80'(1));
      idle_inputs();
      @(posedge i_clk); #5;
      chk("tmo err pulse", 80'(o_err), 80'(0));
      chk("tmo stall after", 80'(o_stall), 80'(0));
`else
      ok = 1'b1;
      for (int unsigned cyc = 0; cyc < 50; cyc++) begin
         if (cyc == 1) i_wen = 1'b0;
         #4;
         if (o_stall !== 1'b1 || o_err !== 1'b0) ok = 1'b0;
         @(posedge i_clk); #1;
      end
      chk("no_tmo stall held, err low", 80'(ok), 80'(1));
      chk("no_tmo rd held", 80'(o_rd), 80'(32'h5555AAAA));
      idle_inputs();
      i_rstn = 1'b0;
      @(posedge i_clk); #1;
      i_rstn = 1'b1;
      #4;
      chk("no_tmo recover valid", 80'(o_bus_valid), 80'(0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
